// File: rtl/milano_lsu_ctrl.sv
// milano load/store sequencer: alignment check, bus request generation,
// req/gnt/rvalid handshake and load-data extension.
module milano_lsu_ctrl #(
    parameter int AW = 32,
    parameter int DW = 32
) (
    input  logic          clk_i,
    input  logic          rst_ni,
    input  logic          lsu_req_i,
    input  logic [3:0]    lsu_opt_i,
    input  logic [AW-1:0] lsu_addr_i,
    input  logic [DW-1:0] lsu_wdata_i,
    output logic          lsu_ready_o,
    output logic          lsu_valid_o,
    output logic          lsu_err_o,
    output logic [DW-1:0] lsu_rdata_o,
    output logic          data_req_o,
    input  logic          data_gnt_i,
    output logic          data_we_o,
    output logic [3:0]    data_be_o,
    output logic [AW-1:0] data_addr_o,
    output logic [DW-1:0] data_wdata_o,
    input  logic          data_rvalid_i,
    input  logic [DW-1:0] data_rdata_i
);

    typedef enum logic [3:0] {
        LSU_LW   = 4'd0,
        LSU_LH   = 4'd1,
        LSU_LB   = 4'd2,
        LSU_LBU  = 4'd3,
        LSU_LHU  = 4'd4,
        LSU_SB   = 4'd5,
        LSU_SH   = 4'd6,
        LSU_SW   = 4'd7,
        LSU_NONE = 4'd8
    } lsu_opt_e;

    typedef enum logic [1:0] {
        S_IDLE,
        S_REQ,
        S_WAIT_RV
    } state_e;

    state_e          state_q, state_d;
    lsu_opt_e        opt_q, opt_d;
    logic [1:0]      off_q, off_d;
    logic            req_q, req_d;
    logic            we_q, we_d;
    logic [3:0]      be_q, be_d;
    logic [AW-1:0]   addr_q, addr_d;
    logic [DW-1:0]   wdata_q, wdata_d;
    logic            valid_q, valid_d;
    logic            err_q, err_d;
    logic [DW-1:0]   rdata_q, rdata_d;

    logic            is_byte, is_half, is_word, is_store;
    logic            misal, accept;
    logic [1:0]      off_in;
    logic [7:0]      rd_byte;
    logic [15:0]     rd_half;
    logic [DW-1:0]   ext_data;

    assign off_in = lsu_addr_i[1:0];
    assign accept = (state_q == S_IDLE) && lsu_req_i && !lsu_opt_i[3];

    // Classify the incoming operation by access size and direction.
    always_comb begin
        is_byte  = 1'b0;
        is_half  = 1'b0;
        is_word  = 1'b0;
        is_store = 1'b0;
        case (lsu_opt_i)
            LSU_LW:  is_word = 1'b1;
            LSU_LH:  is_half = 1'b1;
            LSU_LB:  is_byte = 1'b1;
            LSU_LBU: is_byte = 1'b1;
            LSU_LHU: is_half = 1'b1;
            LSU_SB: begin
                is_byte  = 1'b1;
                is_store = 1'b1;
            end
            LSU_SH: begin
                is_half  = 1'b1;
                is_store = 1'b1;
            end
            LSU_SW: begin
                is_word  = 1'b1;
                is_store = 1'b1;
            end
            default: ;
        endcase
        misal = (is_word && (off_in != 2'b00)) || (is_half && off_in[0]);
    end

    // Extract and extend load data using the offset captured at accept.
    always_comb begin
        case (off_q)
            2'd0:    rd_byte = data_rdata_i[7:0];
            2'd1:    rd_byte = data_rdata_i[15:8];
            2'd2:    rd_byte = data_rdata_i[23:16];
            default: rd_byte = data_rdata_i[31:24];
        endcase
        rd_half = off_q[1] ? data_rdata_i[31:16] : data_rdata_i[15:0];
        case (opt_q)
            LSU_LW:  ext_data = data_rdata_i;
            LSU_LH:  ext_data = {{16{rd_half[15]}}, rd_half};
            LSU_LHU: ext_data = {16'h0000, rd_half};
            LSU_LB:  ext_data = {{24{rd_byte[7]}}, rd_byte};
            LSU_LBU: ext_data = {24'h000000, rd_byte};
            default: ext_data = '0;
        endcase
    end

    // Sequencer next-state and registered-output computation.
    always_comb begin
        state_d = state_q;
        opt_d   = opt_q;
        off_d   = off_q;
        req_d   = req_q;
        we_d    = we_q;
        be_d    = be_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        valid_d = 1'b0;
        err_d   = err_q;
        rdata_d = rdata_q;
        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    if (misal) begin
                        valid_d = 1'b1;
                        err_d   = 1'b1;
                        rdata_d = '0;
                    end else begin
                        state_d = S_REQ;
                        opt_d   = lsu_opt_e'(lsu_opt_i);
                        off_d   = off_in;
                        req_d   = 1'b1;
                        we_d    = is_store;
                        addr_d  = {lsu_addr_i[AW-1:2], 2'b00};
                        if (is_byte) begin
                            be_d    = 4'b0001 << off_in;
                            wdata_d = {4{lsu_wdata_i[7:0]}};
                        end else if (is_half) begin
                            be_d    = 4'b0011 << off_in;
                            wdata_d = {2{lsu_wdata_i[15:0]}};
                        end else begin
                            be_d    = 4'b1111;
                            wdata_d = lsu_wdata_i;
                        end
                    end
                end
            end
            S_REQ: begin
                if (data_gnt_i) begin
                    state_d = S_WAIT_RV;
                    req_d   = 1'b0;
                end
            end
            S_WAIT_RV: begin
                if (data_rvalid_i) begin
                    state_d = S_IDLE;
                    valid_d = 1'b1;
                    err_d   = 1'b0;
                    rdata_d = ext_data;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // State and output registers; reset abandons any access in flight.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= S_IDLE;
            opt_q   <= LSU_LW;
            off_q   <= 2'b00;
            req_q   <= 1'b0;
            we_q    <= 1'b0;
            be_q    <= 4'b0000;
            addr_q  <= '0;
            wdata_q <= '0;
            valid_q <= 1'b0;
            err_q   <= 1'b0;
            rdata_q <= '0;
        end else begin
            state_q <= state_d;
            opt_q   <= opt_d;
            off_q   <= off_d;
            req_q   <= req_d;
            we_q    <= we_d;
            be_q    <= be_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            valid_q <= valid_d;
            err_q   <= err_d;
            rdata_q <= rdata_d;
        end
    end

    assign lsu_ready_o  = (state_q == S_IDLE);
    assign lsu_valid_o  = valid_q;
    assign lsu_err_o    = err_q;
    assign lsu_rdata_o  = rdata_q;
    assign data_req_o   = req_q;
    assign data_we_o    = we_q;
    assign data_be_o    = be_q;
    assign data_addr_o  = addr_q;
    assign data_wdata_o = wdata_q;

endmodule

// File: tb/tb_milano_lsu_ctrl.sv
// Self-checking bench for milano_lsu_ctrl: transaction-level model plus
// per-cycle compare of handshake, bus fields and completion results.
module tb_milano_lsu_ctrl;

    logic        clk_i = 1'b0;
    logic        rst_ni;
    logic        lsu_req_i;
    logic [3:0]  lsu_opt_i;
    logic [31:0] lsu_addr_i;
    logic [31:0] lsu_wdata_i;
    logic        lsu_ready_o;
    logic        lsu_valid_o;
    logic        lsu_err_o;
    logic [31:0] lsu_rdata_o;
    logic        data_req_o;
    logic        data_gnt_i;
    logic        data_we_o;
    logic [3:0]  data_be_o;
    logic [31:0] data_addr_o;
    logic [31:0] data_wdata_o;
    logic        data_rvalid_i;
    logic [31:0] data_rdata_i;

    milano_lsu_ctrl #(.AW(32), .DW(32)) dut (
        .clk_i         (clk_i),
        .rst_ni        (rst_ni),
        .lsu_req_i     (lsu_req_i),
        .lsu_opt_i     (lsu_opt_i),
        .lsu_addr_i    (lsu_addr_i),
        .lsu_wdata_i   (lsu_wdata_i),
        .lsu_ready_o   (lsu_ready_o),
        .lsu_valid_o   (lsu_valid_o),
        .lsu_err_o     (lsu_err_o),
        .lsu_rdata_o   (lsu_rdata_o),
        .data_req_o    (data_req_o),
        .data_gnt_i    (data_gnt_i),
        .data_we_o     (data_we_o),
        .data_be_o     (data_be_o),
        .data_addr_o   (data_addr_o),
        .data_wdata_o  (data_wdata_o),
        .data_rvalid_i (data_rvalid_i),
        .data_rdata_i  (data_rdata_i)
    );

    always #5 clk_i = ~clk_i;

    int pass_cnt = 0;
    int tot_cnt  = 0;

    // Expected values for the cycle following the next rising edge.
    logic        exp_ready = 1'b1;
    logic        exp_req   = 1'b0;
    logic        exp_valid = 1'b0;
    logic        exp_err   = 1'b0;
    logic [31:0] exp_rdata = '0;
    logic [31:0] exp_addr  = '0;
    logic [3:0]  exp_be    = '0;
    logic        exp_we    = 1'b0;
    logic [31:0] exp_wdata = '0;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] req);
        tot_cnt++;
        if (act === req) pass_cnt++;
        else $display("FAIL %s actual=%h required=%h", nm, act, req);
    endtask

    // Access size in bytes: words 4, halves 2, bytes 1.
    function automatic int m_size(input logic [3:0] o);
        case (o)
            4'd0, 4'd7:       return 4;
            4'd1, 4'd4, 4'd6: return 2;
            default:          return 1;
        endcase
    endfunction

    function automatic logic m_mis(input logic [3:0] o, input logic [31:0] a);
        return (int'(a[1:0]) % m_size(o)) != 0;
    endfunction

    function automatic logic [3:0] m_be(input logic [3:0] o, input logic [31:0] a);
        int v;
        v = ((1 << m_size(o)) - 1) << a[1:0];
        return v[3:0];
    endfunction

    function automatic logic [31:0] m_wdata(input logic [3:0] o, input logic [31:0] w);
        case (m_size(o))
            1:       return {4{w[7:0]}};
            2:       return {2{w[15:0]}};
            default: return w;
        endcase
    endfunction

    function automatic logic [31:0] m_load(input logic [3:0] o, input logic [31:0] a,
                                           input logic [31:0] rd);
        logic [31:0] s;
        s = rd >> (8 * int'(a[1:0]));
        if (o >= 4'd5) return 32'h0;
        if (m_size(o) == 4) return rd;
        if (m_size(o) == 2)
            return (o == 4'd1) ? {{16{s[15]}}, s[15:0]} : {16'h0, s[15:0]};
        return (o == 4'd2) ? {{24{s[7]}}, s[7:0]} : {24'h0, s[7:0]};
    endfunction

    // Per-cycle compare, sampled just after each rising edge.
    initial begin
        forever begin
            @(posedge clk_i);
            #1;
            chk("ready", 32'(lsu_ready_o), 32'(exp_ready));
            chk("bus_req", 32'(data_req_o), 32'(exp_req));
            chk("valid", 32'(lsu_valid_o), 32'(exp_valid));
            if (exp_req) begin
                chk("bus_addr", data_addr_o, exp_addr);
                chk("bus_be", 32'(data_be_o), 32'(exp_be));
                chk("bus_we", 32'(data_we_o), 32'(exp_we));
                if (exp_we) chk("bus_wdata", data_wdata_o, exp_wdata);
            end
            if (exp_valid) begin
                chk("err", 32'(lsu_err_o), 32'(exp_err));
                chk("rdata", lsu_rdata_o, exp_rdata);
            end
        end
    end

    task automatic idle();
        @(negedge clk_i);
        lsu_req_i     = 1'b0;
        data_gnt_i    = 1'b0;
        data_rvalid_i = 1'b0;
        exp_ready     = 1'b1;
        exp_req       = 1'b0;
        exp_valid     = 1'b0;
    endtask

    // One operation; gd = grant wait cycles, rd = bus read data.
    task automatic op(input logic [3:0] o, input logic [31:0] a,
                      input logic [31:0] w, input int gd, input logic [31:0] rd);
        logic mis;
        mis = m_mis(o, a);
        @(negedge clk_i);
        data_gnt_i    = 1'b0;
        data_rvalid_i = 1'b0;
        lsu_req_i     = 1'b1;
        lsu_opt_i     = o;
        lsu_addr_i    = a;
        lsu_wdata_i   = w;
        exp_addr      = a & ~32'h3;
        exp_be        = m_be(o, a);
        exp_we        = (o >= 4'd5);
        exp_wdata     = m_wdata(o, w);
        exp_ready     = mis;
        exp_req       = !mis;
        exp_valid     = mis;
        exp_err       = 1'b1;
        exp_rdata     = 32'h0;
        if (!mis) begin
            for (int k = 0; k <= gd; k++) begin
                @(negedge clk_i);
                lsu_req_i  = 1'b0;
                data_gnt_i = (k == gd);
                exp_ready  = 1'b0;
                exp_req    = (k != gd);
                exp_valid  = 1'b0;
            end
            @(negedge clk_i);
            data_gnt_i    = 1'b0;
            data_rvalid_i = 1'b1;
            data_rdata_i  = rd;
            exp_ready     = 1'b1;
            exp_req       = 1'b0;
            exp_valid     = 1'b1;
            exp_err       = 1'b0;
            exp_rdata     = m_load(o, a, rd);
        end
    endtask

    initial begin
        rst_ni        = 1'b0;
        lsu_req_i     = 1'b0;
        lsu_opt_i     = 4'd8;
        lsu_addr_i    = '0;
        lsu_wdata_i   = '0;
        data_gnt_i    = 1'b0;
        data_rvalid_i = 1'b0;
        data_rdata_i  = '0;
        #3;
        chk("rst_err", 32'(lsu_err_o), 32'h0);
        chk("rst_rdata", lsu_rdata_o, 32'h0);
        chk("rst_be", 32'(data_be_o), 32'h0);
        chk("rst_addr", data_addr_o, 32'h0);
        chk("rst_we", 32'(data_we_o), 32'h0);
        chk("rst_wdata", data_wdata_o, 32'h0);
        repeat (2) @(negedge clk_i);
        rst_ni = 1'b1;

        chk("pin_be_sb", 32'(m_be(4'd5, 32'h203)), 32'h8);
        chk("pin_wd_sb", m_wdata(4'd5, 32'hA5), 32'hA5A5A5A5);
        chk("pin_be_sh", 32'(m_be(4'd6, 32'h406)), 32'hC);

        op(4'd0, 32'h100, 32'h0, 0, 32'hDEADBEEF);
        idle();
        chk("lw_lit", lsu_rdata_o, 32'hDEADBEEF);

        op(4'd5, 32'h203, 32'h000000A5, 1, 32'h55555555);
        idle();
        chk("sb_lit", lsu_rdata_o, 32'h0);

        op(4'd2, 32'h302, 32'h0, 0, 32'h12F03456);
        idle();
        chk("lb_lit", lsu_rdata_o, 32'hFFFFFFF0);
        op(4'd3, 32'h302, 32'h0, 0, 32'h12F03456);
        idle();
        chk("lbu_lit", lsu_rdata_o, 32'h000000F0);
        op(4'd4, 32'h302, 32'h0, 2, 32'h12F03456);
        idle();
        chk("lhu_lit", lsu_rdata_o, 32'h000012F0);
        op(4'd1, 32'h501, 32'h0, 0, 32'h8001FFFF);
        op(4'd1, 32'h502, 32'h0, 0, 32'h8001FFFF);
        idle();
        chk("lh_lit", lsu_rdata_o, 32'hFFFF8001);

        op(4'd1, 32'h1001, 32'h0, 0, 32'h0);
        idle();
        chk("mis_lh_err", 32'(lsu_err_o), 32'h1);
        op(4'd7, 32'h1002, 32'h12345678, 0, 32'h0);
        idle();
        chk("mis_sw_err", 32'(lsu_err_o), 32'h1);
        chk("mis_sw_rdata", lsu_rdata_o, 32'h0);

        op(4'd6, 32'h406, 32'h0000BEEF, 3, 32'h0);
        op(4'd0, 32'h40C, 32'h0, 0, 32'h11223344);
        op(4'd7, 32'h410, 32'hCAFEF00D, 0, 32'h0);
        op(4'd3, 32'h411, 32'h0, 1, 32'h0000C300);
        idle();
        chk("b2b_lit", lsu_rdata_o, 32'h000000C3);

        @(negedge clk_i);
        lsu_req_i = 1'b1;
        lsu_opt_i = 4'd8;
        @(negedge clk_i);
        lsu_opt_i = 4'd15;
        idle();

        @(negedge clk_i);
        lsu_req_i  = 1'b1;
        lsu_opt_i  = 4'd0;
        lsu_addr_i = 32'h500;
        exp_addr   = 32'h500;
        exp_be     = 4'hF;
        exp_we     = 1'b0;
        exp_ready  = 1'b0;
        exp_req    = 1'b1;
        exp_valid  = 1'b0;
        @(negedge clk_i);
        lsu_req_i  = 1'b0;
        data_gnt_i = 1'b1;
        exp_req    = 1'b0;
        @(negedge clk_i);
        data_gnt_i = 1'b0;
        @(negedge clk_i);
        rst_ni = 1'b0;
        #1;
        chk("arst_ready", 32'(lsu_ready_o), 32'h1);
        chk("arst_req", 32'(data_req_o), 32'h0);
        chk("arst_be", 32'(data_be_o), 32'h0);
        chk("arst_addr", data_addr_o, 32'h0);
        exp_ready = 1'b1;
        @(negedge clk_i);
        rst_ni = 1'b1;
        @(negedge clk_i);
        data_rvalid_i = 1'b1;
        data_rdata_i  = 32'hFFFFFFFF;
        idle();
        idle();
        chk("stray_rdata", lsu_rdata_o, 32'h0);

        op(4'd4, 32'h602, 32'h0, 0, 32'hABCD0000);
        idle();
        chk("post_rst_lit", lsu_rdata_o, 32'h0000ABCD);
        idle();

        $display("%0d/%0d checks passed", pass_cnt, tot_cnt);
        $finish;
    end

endmodule

// File: doc/milano_lsu_ctrl.md
Name: milano_lsu_ctrl

Overview:
- Load/store sequencer between the milano execute stage and the data-memory bus.
- Accepts one milano_pkg::lsu_opt_e operation at a time and checks alignment.
- Generates the word address, byte enables and replicated write data, and runs a req/gnt/rvalid handshake.
- Returns sign- or zero-extended load data with a single-cycle completion pulse.

Parameters:
- AW, 32, address width (bits)
- DW, 32, data width; fixed at 32, with 4 byte enables

Ports:
- clk_i  in  1  clock
- rst_ni  in  1  asynchronous reset, active-low
- lsu_req_i  in  1  operation request from EX
- lsu_opt_i  in  4  milano_pkg::lsu_opt_e (LW=0 LH=1 LB=2 LBU=3 LHU=4 SB=5 SH=6 SW=7 NONE=8)
- lsu_addr_i  in  AW  effective byte address
- lsu_wdata_i  in  32  store data (low bits significant)
- lsu_ready_o  out  1  controller can accept a request
- lsu_valid_o  out  1  one-cycle completion pulse
- lsu_err_o  out  1  misaligned access; qualified by lsu_valid_o
- lsu_rdata_o  out  32  extended load data; qualified by lsu_valid_o
- data_req_o  out  1  bus request
- data_gnt_i  in  1  bus grant
- data_we_o  out  1  1 = write
- data_be_o  out  4  byte enables
- data_addr_o  out  AW  word address, {addr[AW-1:2],2'b00}
- data_wdata_o  out  32  write data
- data_rvalid_i  in  1  response valid (loads and stores)
- data_rdata_i  in  32  read data

Behaviour:
- Reset values: state IDLE; every output 0 except lsu_ready_o = 1.
- Async reset mid-transaction abandons the access. data_req_o drops immediately; no lsu_valid_o is produced.
- FSM states: IDLE, REQ, WAIT_RV. lsu_ready_o = (state == IDLE), combinational.
- Accept condition: IDLE && lsu_req_i && lsu_opt_i <= 7. Encodings 8..15 are ignored; no state change, no response.
- Alignment rule: LW/SW need addr[1:0] = 0; LH/LHU/SH need addr[0] = 0; byte operations are always aligned.
- Misaligned accept (cycle N):
  - no bus activity and state stays IDLE;
  - at N+1: lsu_valid_o = lsu_err_o = 1 and lsu_rdata_o = 0, for exactly one cycle.
- Aligned accept (cycle N):
  - register opt, addr[1:0] and the bus fields;
  - move to REQ; data_req_o = 1 from N+1.
- REQ state:
  - data_req_o, data_we_o, data_be_o, data_addr_o and data_wdata_o are registered and held stable until a cycle where data_gnt_i = 1;
  - that cycle is the handshake; next state is WAIT_RV and data_req_o = 0 from the next cycle.
- WAIT_RV state:
  - on data_rvalid_i, at the next cycle: lsu_valid_o = 1 for one cycle, lsu_err_o = 0, lsu_rdata_o = extended data (stores: 0); state becomes IDLE in the same edge;
  - a new request may be accepted in the cycle lsu_valid_o is high.
- rvalid arrives at the earliest one cycle after gnt. data_rvalid_i outside WAIT_RV is ignored.
- Byte enables, with off = addr[1:0]:
  - SB/LB/LBU: 4'b0001 << off
  - SH/LH/LHU: 4'b0011 << off
  - SW/LW: 4'b1111
- data_we_o = 1 for SB/SH/SW only.
- Write data: SB → {4{wdata[7:0]}}; SH → {2{wdata[15:0]}}; SW → wdata.
- Load extraction, with off taken from the stored offset:
  - byte = rdata[8*off +: 8]; half = rdata[16*off[1] +: 16];
  - LB sign-extends byte, LBU zero-extends byte;
  - LH sign-extends half, LHU zero-extends half;
  - LW passes rdata through.
- lsu_rdata_o and lsu_err_o hold their values when lsu_valid_o = 0. Only the pulse is meaningful.
- Latency with zero-wait bus (gnt at N+1, rvalid at N+2): lsu_valid_o at N+3.

Test Plan:
- LW addr 0x100, gnt at first req cycle, rvalid next cycle with rdata 0xDEADBEEF → data_addr_o 0x100, be 4'b1111, we 0; lsu_valid_o at N+3, rdata 0xDEADBEEF, err 0.
- SB addr 0x203, wdata 0x000000A5 → data_addr_o 0x200, be 4'b1000, wdata 0xA5A5A5A5, we 1; completion pulse after rvalid, rdata 0.
- LB addr 0x302 with rdata 0x12F03456, then LBU with same address and data → LB rdata 0xFFFFFFF0; LBU rdata 0x000000F0; LHU addr 0x302 → 0x000012F0.
- LH addr 0x1001, then SW addr 0x1002 → data_req_o never asserted; each gives lsu_valid_o = lsu_err_o = 1 exactly one cycle after accept, rdata 0.
- SH addr 0x406, data_gnt_i withheld 3 cycles → req/addr/be (4'b1100)/wdata stable all 4 req cycles; lsu_ready_o = 0 throughout; back-to-back request accepted in the lsu_valid_o cycle.
- rst_ni low in WAIT_RV, then rvalid after release → outputs at reset values immediately; stray rvalid ignored, no lsu_valid_o.
